// File: rtl/mindu_pkg.sv
// Shared types and the seven-segment code table for the mindu scan driver.
package mindu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment code, [0]=A ... [6]=G; anything that is not BCD shows blank.
    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/mindu_bin2bcd.sv
// Sequential double-dabble converter: one shift-add-3 step per clock.
// start loads the operand; done is high in the cycle whose closing edge performs
// the final step, so bcd holds the finished result from the following cycle on.
module mindu_bin2bcd
    import mindu_pkg::*;
#(
    parameter int BIN_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [CNT_W-1:0]        steps_left;
    logic [BIN_W-1:0]        shreg;
    logic [4*NUM_DIGITS-1:0] adj;

    // Add 3 to every BCD digit that would overflow past 9 after the next shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Operand load on start, then shift the adjusted digits and operand left once per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            steps_left <= '0;
            shreg      <= '0;
            bcd        <= '0;
        end else if (start) begin
            steps_left <= CNT_W'(BIN_W);
            shreg      <= bin;
            bcd        <= '0;
        end else if (steps_left != '0) begin
            {bcd, shreg} <= {adj, shreg} << 1;
            steps_left   <= steps_left - 1'b1;
        end
    end

    assign done = (steps_left == CNT_W'(1));

endmodule

// File: rtl/mindu_scan_driver.sv
// Multi-digit time-multiplexed decimal display driver (common-anode, active-low).
// Build option: define MINDU_LZ_BLANK_EN to blank leading zeros (digit 0 always shown).
//
//  state | meaning
//  IDLE  | display shows committed value, load_ready=1
//  CONV  | BIN_W double-dabble steps in flight, old value still displayed
//  DONE  | one cycle, commit digits/overflow/valid to the display registers
module mindu_scan_driver
    import mindu_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [BIN_W-1:0]      bin_num,
    output logic                  busy,
    output logic [6:0]            Segments,
    output logic [NUM_DIGITS-1:0] Anodes
);

    localparam int unsigned LIMIT = 10 ** NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);

    state_t                  state, state_next;
    logic                    accept;
    logic                    conv_done;
    logic                    ovf_q;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic                    disp_ovf;
    logic                    disp_valid;
    logic [REF_W-1:0]        refresh_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    digit_blank;

    mindu_bin2bcd #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (bin_num),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Handshake FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and handshake outputs; loads outside IDLE are simply dropped.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    accept     = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (conv_done) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Range check at accept time; the converter only holds NUM_DIGITS digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       ovf_q <= 1'b0;
        else if (accept) ovf_q <= ({1'b0, bin_num} >= (BIN_W+1)'(LIMIT));
    end

    // Display registers change only in DONE, so the old value stays up during conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_bcd   <= '0;
            disp_ovf   <= 1'b0;
            disp_valid <= 1'b0;
        end else if (state == DONE) begin
            disp_bcd   <= bcd;
            disp_ovf   <= ovf_q;
            disp_valid <= 1'b1;
        end
    end

    // Refresh timer; each wrap moves the scan to the next digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            if (digit_idx == IDX_W'(NUM_DIGITS - 1)) digit_idx <= '0;
            else                                     digit_idx <= digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

`ifdef MINDU_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic seen_nonzero;
        seen_nonzero = 1'b0;
        lz_blank     = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen_nonzero = seen_nonzero | (disp_bcd[4*i +: 4] != 4'd0);
            lz_blank[i]  = ~seen_nonzero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign digit_blank = ~disp_valid | disp_ovf | lz_blank[digit_idx];

    // Registered pin drivers so segments and anode switch on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Segments <= SEG_BLANK;
            Anodes   <= '1;
        end else begin
            Segments <= digit_blank ? SEG_BLANK : seg_of(disp_bcd[4*digit_idx +: 4]);
            Anodes   <= ~(NUM_DIGITS'(1) << digit_idx);
        end
    end

endmodule
